geri_yaz_asamasi: RTL and testbench
===================================

# geri_yaz_asamasi

Write-back stage of the in-order RISC-V core. It takes the destination register, the result candidates and the micro-op class from the execute stage (YURUT). It selects the value to retire and presents a registered register-file write request (address, data, enable) to the decode/register-file stage (COZ). One pipeline register sits between YURUT and COZ.

## Interface
Parameters:
- none. All widths are fixed: 32-bit data, 5-bit register address, 3-bit micro-op.

Ports:
- clk_i  in  1  single clock; all state changes on its rising edge
- rst_ni  in  1  asynchronous, active-low reset
- durdur_i  in  1  stall; when 1 the output register holds its contents
- yrt_rd_adres_i  in  5  destination register index rd
- yrt_rd_deger_i  in  32  ALU / load result
- yrt_mikroislem_i  in  3  write-back micro-op, selects the source
- yrt_carpma_deger_i  in  32  multiplier / divider result
- yrt_ps_artmis_i  in  31  incremented PC (PC+2/PC+4), bits [31:1]; bit 0 is implicitly 0
- cyo_yaz_adres_o  out  5  register-file write address
- cyo_yaz_deger_o  out  32  register-file write data
- cyo_yaz_yazmac_o  out  1  register-file write enable

## Operation
Micro-op decode (combinational, before the output register):
- 3'b000 (YOK: store, branch, fence, bubble): enable 0, data 32'h0000_0000.
- 3'b001 (ALU / load): enable 1, data = yrt_rd_deger_i.
- 3'b010 (multiply / divide): enable 1, data = yrt_carpma_deger_i.
- 3'b011 (JAL / JALR link): enable 1, data = {yrt_ps_artmis_i, 1'b0}.
- 3'b100 to 3'b111 (reserved): enable 0, data 32'h0000_0000.

Other rules:
- x0 protection: if yrt_rd_adres_i == 0, the enable is forced to 0 for every micro-op. The data is computed normally.
- The address output always carries yrt_rd_adres_i, regardless of the enable.
- No arithmetic is performed. The data path is a pure 4-way selection with zero default.
- Unselected candidate inputs have no effect on the outputs.

## Timing
- Latency is 1 cycle. The decoded (address, data, enable) is captured on the rising edge of clk_i and appears on the outputs after that edge.
- Reset: while rst_ni = 0, all outputs are 0 immediately, independent of the clock. The first capture happens on the first rising edge after rst_ni rises.
- Stall: when durdur_i = 1 on an edge, all three outputs keep their previous values and the inputs are ignored for that edge.
- Reset overrides stall.
- Back-to-back micro-ops: each edge without stall retires the current input. There is no internal buffering beyond the single register.
- Reset asserted mid-stream discards any pending output; the outputs show 0 within the reset assertion, with no clock needed.
- No handshake beyond durdur_i. The stage always accepts a new input when not stalled.

## Test plan
Common inputs: rd = 5'h06, rd_deger = 32'h0000_FFFF, carpma = 32'hFFFF_0000, ps_artmis = all ones. Apply each micro-op and check after the next clock edge.

- Micro-op 000, then 001 -> 000 gives adres 06, deger 0000_0000, yazmac 0; 001 gives adres 06, deger 0000_FFFF, yazmac 1.
- Micro-op 010, then 011 -> 010 gives deger FFFF_0000, yazmac 1; 011 gives deger FFFF_FFFE, yazmac 1.
- Micro-ops 101, 110, 111 in turn -> each gives yazmac 0, deger 0000_0000, adres 06.
- rd = 0 with micro-op 001 -> yazmac 0, adres 00, deger 0000_FFFF.
- Stall and reset sequence:
  - Retire 001, then set durdur_i = 1 and change the micro-op to 010 for 3 cycles -> outputs stay 06 / 0000_FFFF / 1.
  - Release the stall -> the next edge shows FFFF_0000.
- Pull rst_ni low between clock edges -> all outputs 0 immediately. Release reset, apply 011 -> FFFF_FFFE appears one edge later.

Source files
------------

// File: rtl/geri_yaz_asamasi_if.sv
// rtl/geri_yaz_asamasi_if.sv - execute-to-writeback input bundle and register-file write request bundle
// master drives the execute-side candidates and observes the write request; slave is the write-back stage.
interface geri_yaz_asamasi_if;
   logic [4:0]  yrt_rd_adres_i;
   logic [31:0] yrt_rd_deger_i;
   logic [2:0]  yrt_mikroislem_i;
   logic [31:0] yrt_carpma_deger_i;
   logic [30:0] yrt_ps_artmis_i;
   logic [4:0]  cyo_yaz_adres_o;
   logic [31:0] cyo_yaz_deger_o;
   logic        cyo_yaz_yazmac_o;

   modport master (
      output yrt_rd_adres_i, yrt_rd_deger_i, yrt_mikroislem_i,
             yrt_carpma_deger_i, yrt_ps_artmis_i,
      input  cyo_yaz_adres_o, cyo_yaz_deger_o, cyo_yaz_yazmac_o
   );

   modport slave (
      input  yrt_rd_adres_i, yrt_rd_deger_i, yrt_mikroislem_i,
             yrt_carpma_deger_i, yrt_ps_artmis_i,
      output cyo_yaz_adres_o, cyo_yaz_deger_o, cyo_yaz_yazmac_o
   );
endinterface

// File: rtl/geri_yaz_asamasi.sv
// rtl/geri_yaz_asamasi.sv - write-back stage: selects the retiring value and registers the register-file write
// One pipeline register between execute and decode; stall holds it, async reset clears it.
module geri_yaz_asamasi (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 durdur_i,
   geri_yaz_asamasi_if.slave    bus
);

   localparam logic [2:0] MO_YOK   = 3'b000;
   localparam logic [2:0] MO_ALU   = 3'b001;
   localparam logic [2:0] MO_CARP  = 3'b010;
   localparam logic [2:0] MO_BAGLA = 3'b011;

   logic [31:0] secili_deger;
   logic        secili_yazmac;

   always_comb begin
      secili_deger  = 32'h0000_0000;
      secili_yazmac = 1'b0;
      case (bus.yrt_mikroislem_i)
         MO_ALU: begin
            secili_deger  = bus.yrt_rd_deger_i;
            secili_yazmac = 1'b1;
         end
         MO_CARP: begin
            secili_deger  = bus.yrt_carpma_deger_i;
            secili_yazmac = 1'b1;
         end
         MO_BAGLA: begin
            secili_deger  = {bus.yrt_ps_artmis_i, 1'b0};
            secili_yazmac = 1'b1;
         end
         default: begin
            secili_deger  = 32'h0000_0000;
            secili_yazmac = 1'b0;
         end
      endcase
      // x0 is hardwired to zero, so never request a write to it
      if (bus.yrt_rd_adres_i == 5'd0) begin
         secili_yazmac = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bus.cyo_yaz_adres_o  <= 5'd0;
         bus.cyo_yaz_deger_o  <= 32'h0000_0000;
         bus.cyo_yaz_yazmac_o <= 1'b0;
      end else if (!durdur_i) begin
         bus.cyo_yaz_adres_o  <= bus.yrt_rd_adres_i;
         bus.cyo_yaz_deger_o  <= secili_deger;
         bus.cyo_yaz_yazmac_o <= secili_yazmac;
      end
   end

endmodule

// File: tb/tb_geri_yaz_asamasi.sv
// tb/tb_geri_yaz_asamasi.sv - self-checking bench for the write-back stage
module tb_geri_yaz_asamasi;

   logic clk_i = 1'b0;
   logic rst_ni;
   logic durdur_i;

   geri_yaz_asamasi_if bus ();

   geri_yaz_asamasi dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .durdur_i (durdur_i),
      .bus      (bus.slave)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [2:0]  mo;
      logic [4:0]  rd;
      logic [4:0]  exp_adres;
      logic [31:0] exp_deger;
      logic        exp_yaz;
   } vektor_t;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [4:0] ea, input logic [31:0] ed, input logic ey);
      n_vec++;
      if (bus.cyo_yaz_adres_o !== ea || bus.cyo_yaz_deger_o !== ed || bus.cyo_yaz_yazmac_o !== ey) begin
         n_err++;
         $display("FAIL %s: got adres=%h deger=%h yazmac=%b, want adres=%h deger=%h yazmac=%b",
                  name, bus.cyo_yaz_adres_o, bus.cyo_yaz_deger_o, bus.cyo_yaz_yazmac_o, ea, ed, ey);
      end
   endtask

   task automatic drive(input logic [2:0] mo, input logic [4:0] rd, input logic [31:0] dg,
                        input logic [31:0] cp, input logic [30:0] ps);
      bus.yrt_mikroislem_i   = mo;
      bus.yrt_rd_adres_i     = rd;
      bus.yrt_rd_deger_i     = dg;
      bus.yrt_carpma_deger_i = cp;
      bus.yrt_ps_artmis_i    = ps;
   endtask

   task automatic edge_then_settle();
      @(posedge clk_i);
      #1;
   endtask

   // Reference: what the register file should be asked to write for one retiring micro-op
   function automatic logic [31:0] ref_deger(input logic [2:0] mo, input logic [31:0] dg,
                                             input logic [31:0] cp, input logic [30:0] ps);
      if (mo == 3'd1) return dg;
      if (mo == 3'd2) return cp;
      if (mo == 3'd3) return {ps, 1'b0};
      return 32'd0;
   endfunction

   function automatic logic ref_yaz(input logic [2:0] mo, input logic [4:0] rd);
      return (mo >= 3'd1) && (mo <= 3'd3) && (rd != 5'd0);
   endfunction

   localparam logic [31:0] C_DG = 32'h0000_FFFF;
   localparam logic [31:0] C_CP = 32'hFFFF_0000;
   localparam logic [30:0] C_PS = 31'h7FFF_FFFF;

   vektor_t tablo [8];

   logic [4:0]  m_adres;
   logic [31:0] m_deger;
   logic        m_yaz;

   initial begin
      tablo[0] = '{3'b000, 5'h06, 5'h06, 32'h0000_0000, 1'b0};
      tablo[1] = '{3'b001, 5'h06, 5'h06, 32'h0000_FFFF, 1'b1};
      tablo[2] = '{3'b010, 5'h06, 5'h06, 32'hFFFF_0000, 1'b1};
      tablo[3] = '{3'b011, 5'h06, 5'h06, 32'hFFFF_FFFE, 1'b1};
      tablo[4] = '{3'b101, 5'h06, 5'h06, 32'h0000_0000, 1'b0};
      tablo[5] = '{3'b110, 5'h06, 5'h06, 32'h0000_0000, 1'b0};
      tablo[6] = '{3'b111, 5'h06, 5'h06, 32'h0000_0000, 1'b0};
      tablo[7] = '{3'b001, 5'h00, 5'h00, 32'h0000_FFFF, 1'b0};

      rst_ni   = 1'b0;
      durdur_i = 1'b0;
      drive(3'b001, 5'h06, C_DG, C_CP, C_PS);
      #1;
      check("reset_state", 5'h00, 32'h0, 1'b0);
      edge_then_settle();
      check("reset_holds_over_edge", 5'h00, 32'h0, 1'b0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      for (int i = 0; i < 8; i++) begin
         @(negedge clk_i);
         drive(tablo[i].mo, tablo[i].rd, C_DG, C_CP, C_PS);
         edge_then_settle();
         check($sformatf("table_%0d_mo%b", i, tablo[i].mo),
               tablo[i].exp_adres, tablo[i].exp_deger, tablo[i].exp_yaz);
      end

      // Stall holds the retired ALU result while the input changes underneath
      @(negedge clk_i);
      drive(3'b001, 5'h06, C_DG, C_CP, C_PS);
      edge_then_settle();
      check("pre_stall_alu", 5'h06, 32'h0000_FFFF, 1'b1);
      @(negedge clk_i);
      durdur_i = 1'b1;
      drive(3'b010, 5'h06, C_DG, C_CP, C_PS);
      for (int k = 0; k < 3; k++) begin
         edge_then_settle();
         check($sformatf("stall_hold_%0d", k), 5'h06, 32'h0000_FFFF, 1'b1);
      end
      @(negedge clk_i);
      durdur_i = 1'b0;
      edge_then_settle();
      check("stall_release", 5'h06, 32'hFFFF_0000, 1'b1);

      // Asynchronous reset between edges, with stall asserted to show reset wins
      durdur_i = 1'b1;
      #2;
      rst_ni = 1'b0;
      #1;
      check("async_reset_mid_cycle", 5'h00, 32'h0, 1'b0);
      @(negedge clk_i);
      rst_ni   = 1'b1;
      durdur_i = 1'b0;
      drive(3'b011, 5'h06, C_DG, C_CP, C_PS);
      #1;
      check("after_release_before_edge", 5'h00, 32'h0, 1'b0);
      edge_then_settle();
      check("first_capture_after_reset", 5'h06, 32'hFFFF_FFFE, 1'b1);

      // Randomized run against the reference with random stalls
      m_adres = bus.cyo_yaz_adres_o == 5'h06 ? 5'h06 : 5'h00;
      m_deger = 32'hFFFF_FFFE;
      m_yaz   = 1'b1;
      for (int r = 0; r < 400; r++) begin
         logic [2:0]  mo;
         logic [4:0]  rd;
         logic [31:0] dg, cp;
         logic [30:0] ps;
         logic        st;
         @(negedge clk_i);
         mo = 3'($urandom_range(0, 7));
         rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         dg = $urandom;
         cp = $urandom;
         ps = 31'($urandom);
         st = ($urandom_range(0, 3) == 0);
         durdur_i = st;
         drive(mo, rd, dg, cp, ps);
         if (!st) begin
            m_adres = rd;
            m_deger = ref_deger(mo, dg, cp, ps);
            m_yaz   = ref_yaz(mo, rd);
         end
         edge_then_settle();
         check($sformatf("rand_%0d_mo%b_rd%0d_st%b", r, mo, rd, st), m_adres, m_deger, m_yaz);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
